// File: rtl/instruction_l2_refill_pkg.sv
// Shared widths, FSM encoding and logic-level constants for the instruction-side L2 refill engine.
package instruction_l2_refill_pkg;

  localparam int ADDRESS_WIDTH       = 32;
  localparam int WORD_SIZE           = 4;
  localparam int WORD_PER_BLOCK      = 16;
  localparam int L2_BUS_WIDTH        = 32;
  localparam int WORD_WIDTH          = WORD_SIZE * 8;
  localparam int BLOCK_WIDTH         = WORD_WIDTH * WORD_PER_BLOCK;
  localparam int OFFSET_WIDTH        = $clog2(WORD_SIZE * WORD_PER_BLOCK);
  localparam int BLOCK_ADDRESS_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int BEAT_WIDTH          = $clog2(WORD_PER_BLOCK);
  localparam int BYTE_WIDTH          = OFFSET_WIDTH - BEAT_WIDTH;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/instruction_l2_refill.sv
// Refill engine: takes a block-address miss, reads the block one word at a time from memory,
// and returns the assembled block to the instruction cache.
module instruction_l2_refill
  import instruction_l2_refill_pkg::*;
(
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
  output logic                           ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
  input  logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_INSTRUCTION_CACHE,
  output logic                           DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
  input  logic                           DATA_FROM_L2_READY_INSTRUCTION_CACHE,
  output logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_INSTRUCTION_CACHE,
  output logic [ADDRESS_WIDTH-1:0]       MEM_READ_ADDRESS,
  output logic                           MEM_READ_VALID,
  input  logic                           MEM_READ_READY,
  input  logic                           MEM_DATA_VALID,
  input  logic [L2_BUS_WIDTH-1:0]        MEM_DATA,
  output state_e                         DBG_STATE,
  output logic [BEAT_WIDTH-1:0]          DBG_BEAT
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high; a valid
  // source holds its payload stable until that edge and never withdraws valid beforehand.

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(WORD_PER_BLOCK - 1);

  state_e                         state_q, state_d;
  logic [BEAT_WIDTH-1:0]          beat_q, beat_d;
  logic [BLOCK_ADDRESS_WIDTH-1:0] blk_addr_q, blk_addr_d;
  logic [BLOCK_WIDTH-1:0]         block_q, block_d;
  logic [ADDRESS_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic                           mem_valid_q, mem_valid_d;
  logic                           data_valid_q, data_valid_d;
  logic                           addr_ready_q, addr_ready_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      blk_addr_q   <= '0;
      block_q      <= '0;
      mem_addr_q   <= '0;
      mem_valid_q  <= LOW;
      data_valid_q <= LOW;
      addr_ready_q <= LOW;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      blk_addr_q   <= blk_addr_d;
      block_q      <= block_d;
      mem_addr_q   <= mem_addr_d;
      mem_valid_q  <= mem_valid_d;
      data_valid_q <= data_valid_d;
      addr_ready_q <= addr_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    blk_addr_d   = blk_addr_q;
    block_d      = block_q;
    mem_addr_d   = mem_addr_q;
    mem_valid_d  = mem_valid_q;
    data_valid_d = data_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE && addr_ready_q) begin
          blk_addr_d  = ADDRESS_TO_L2_INSTRUCTION_CACHE;
          beat_d      = '0;
          mem_addr_d  = {ADDRESS_TO_L2_INSTRUCTION_CACHE, {BEAT_WIDTH{1'b0}}, {BYTE_WIDTH{1'b0}}};
          mem_valid_d = HIGH;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (MEM_READ_READY) begin
          mem_valid_d = LOW;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MEM_DATA_VALID) begin
          // Word 0 of the block lands in the most significant bits.
          for (int j = 0; j < WORD_PER_BLOCK; j++) begin
            if (beat_q == BEAT_WIDTH'(j)) begin
              block_d[BLOCK_WIDTH-1-WORD_WIDTH*j -: WORD_WIDTH] = MEM_DATA;
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_d       = '0;
            data_valid_d = HIGH;
            state_d      = ST_RESP;
          end else begin
            beat_d      = beat_q + 1'b1;
            mem_addr_d  = {blk_addr_q, beat_d, {BYTE_WIDTH{1'b0}}};
            mem_valid_d = HIGH;
            state_d     = ST_REQ;
          end
        end
      end
      ST_RESP: begin
        if (DATA_FROM_L2_READY_INSTRUCTION_CACHE) begin
          data_valid_d = LOW;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so the cache sees ready low throughout reset and high from the first cycle after.
    addr_ready_d = (state_d == ST_IDLE);
  end

  assign ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = addr_ready_q;
  assign DATA_FROM_L2_VALID_INSTRUCTION_CACHE  = data_valid_q;
  assign DATA_FROM_L2_INSTRUCTION_CACHE        = block_q;
  assign MEM_READ_ADDRESS                      = mem_addr_q;
  assign MEM_READ_VALID                        = mem_valid_q;
  assign DBG_STATE                             = state_q;
  assign DBG_BEAT                              = beat_q;

endmodule
